// File: rtl/aes_pkg.sv
// Shared types, constants and byte helpers for the AES-128 key schedule.
package aes_pkg;

    localparam int KS_NUM_ROUNDS = 10;
    localparam int KS_RK_IDX_W   = 4;

    // Byte 3 of a word is its first (most significant) byte; word 3 of a block is w0.
    typedef logic [3:0][7:0] aes_word_t;
    typedef aes_word_t [3:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } ks_state_e;

    // Forward S-box; entry for input x lives at SBOX[255-x].
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8'hff - x];
    endfunction

    // Multiply by x in GF(2^8); steps Rcon from one round to the next.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step: previous round key plus Rcon in, next round key out.
module aes_key_round
    import aes_pkg::*;
(
    input  aes_block_t prev,
    input  logic [7:0] rcon,
    output aes_block_t nxt
);

    aes_word_t rot;
    aes_word_t sub;
    aes_word_t g;

    // RotWord then SubWord on w3, then fold in Rcon on the leading byte.
    always_comb begin
        rot = {prev[0][2], prev[0][1], prev[0][0], prev[0][3]};
        for (int i = 0; i < 4; i++) begin
            sub[i] = sbox(rot[i]);
        end
        g = sub ^ {rcon, 24'h0};
    end

    assign nxt[3] = prev[3] ^ g;
    assign nxt[2] = nxt[3] ^ prev[2];
    assign nxt[1] = nxt[2] ^ prev[1];
    assign nxt[0] = nxt[1] ^ prev[0];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: loads a cipher key, writes round keys 0..10 into
// a local store one per cycle, and serves combinational random-access reads.
// Optional build macro AES_KS_ZEROIZE_EN adds a zeroize input that wipes the store.
//
// state  | meaning
// IDLE   | no valid key set; waiting for a key
// EXPAND | writing round key rnd each edge
// READY  | all 11 round keys readable; a new key may be accepted
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = KS_NUM_ROUNDS,
    parameter int RK_IDX_W   = KS_RK_IDX_W
) (
    input  logic                eph1,
    input  logic                reset,
`ifdef AES_KS_ZEROIZE_EN
    input  logic                zeroize,
`endif
    input  logic                key_valid,
    input  logic [127:0]        key_in,
    output logic                key_ready,
    output logic                busy,
    output logic                done,
    output logic                keys_valid,
    input  logic [RK_IDX_W-1:0] rk_rd_idx,
    output logic [127:0]        rk_rd_data,
    output logic                rk_rd_hit,
    output logic                rk_rd_err
);

    localparam logic [RK_IDX_W-1:0] LAST_RND = RK_IDX_W'(NUM_ROUNDS);

    ks_state_e           state_q, state_d;
    logic [RK_IDX_W-1:0] rnd_q;
    logic [7:0]          rcon_q;
    aes_block_t          prev_q;
    aes_block_t          nxt;
    logic [127:0]        store_q [0:NUM_ROUNDS];
    logic                done_q;
    logic                zero_req;
    logic                accept;
    logic                expanding;

`ifdef AES_KS_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    assign expanding = (state_q == EXPAND) & ~reset;
    assign accept    = key_valid & key_ready & ~zero_req & ~reset;

    aes_key_round u_round (
        .prev (prev_q),
        .rcon (rcon_q),
        .nxt  (nxt)
    );

    // State register.
    always_ff @(posedge eph1) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and status outputs.
    always_comb begin
        state_d    = state_q;
        key_ready  = (state_q != EXPAND);
        busy       = (state_q == EXPAND);
        keys_valid = (state_q == READY);
        case (state_q)
            IDLE:    if (accept) state_d = EXPAND;
            EXPAND:  if (rnd_q == LAST_RND) state_d = READY;
            READY:   if (accept) state_d = EXPAND;
            default: state_d = IDLE;
        endcase
        if (zero_req) state_d = IDLE;
    end

    // Round counter, Rcon and the done pulse on the final write.
    always_ff @(posedge eph1) begin
        if (reset || zero_req) begin
            rnd_q  <= '0;
            rcon_q <= 8'h01;
            done_q <= 1'b0;
        end else if (accept) begin
            rnd_q  <= RK_IDX_W'(1);
            rcon_q <= 8'h01;
            done_q <= 1'b0;
        end else if (state_q == EXPAND) begin
            rnd_q  <= rnd_q + 1'b1;
            rcon_q <= xtime(rcon_q);
            done_q <= (rnd_q == LAST_RND);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;

    // Key store and chaining register; contents survive reset, only zeroize clears them.
    always_ff @(posedge eph1) begin
        if (zero_req) begin
            prev_q <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= '0;
        end else if (accept) begin
            prev_q     <= key_in;
            store_q[0] <= key_in;
        end else if (expanding) begin
            prev_q <= nxt;
            for (int i = 1; i <= NUM_ROUNDS; i++) begin
                if (rnd_q == RK_IDX_W'(i)) store_q[i] <= nxt;
            end
        end
    end

    // Combinational read port; out-of-range indices return zero.
    always_comb begin
        rk_rd_err  = (rk_rd_idx > LAST_RND);
        rk_rd_data = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (rk_rd_idx == RK_IDX_W'(i)) rk_rd_data = store_q[i];
        end
        rk_rd_hit = ~rk_rd_err & ((state_q == READY) |
                                  ((state_q == EXPAND) & (rk_rd_idx < rnd_q)));
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl. Stimulus pushes one expected response per
// cycle into a scoreboard queue; a negedge monitor pops and compares.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] RK3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;

    logic         eph1 = 1'b0;
    logic         reset;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready, busy, done, keys_valid;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         rk_rd_hit, rk_rd_err;
`ifdef AES_KS_ZEROIZE_EN
    logic         zeroize = 1'b0;
`endif

    aes_key_sched_ctrl dut (
        .eph1       (eph1),
        .reset      (reset),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data),
        .rk_rd_hit  (rk_rd_hit),
        .rk_rd_err  (rk_rd_err)
    );

    always #5 eph1 = ~eph1;

    typedef struct {
        string        name;
        logic         hit;
        logic         err;
        logic         chkd;
        logic [127:0] data;
        logic         rdy;
        logic         bsy;
        logic         kv;
        logic         dn;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic mon_ok;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    always @(negedge eph1) begin
        while (sb_q.size() > 0) begin
            mon_e  = sb_q.pop_front();
            mon_ok = (rk_rd_hit === mon_e.hit) && (rk_rd_err === mon_e.err) &&
                     (key_ready === mon_e.rdy) && (busy === mon_e.bsy) &&
                     (keys_valid === mon_e.kv) && (done === mon_e.dn) &&
                     (!mon_e.chkd || (rk_rd_data === mon_e.data));
            chk_cnt++;
            if (mon_ok) pass_cnt++;
            else $display("FAIL %s: got hit=%b err=%b rdy=%b busy=%b kv=%b done=%b data=%h ; want hit=%b err=%b rdy=%b busy=%b kv=%b done=%b data=%h (data checked=%b)",
                          mon_e.name, rk_rd_hit, rk_rd_err, key_ready, busy, keys_valid, done, rk_rd_data,
                          mon_e.hit, mon_e.err, mon_e.rdy, mon_e.bsy, mon_e.kv, mon_e.dn, mon_e.data, mon_e.chkd);
        end
    end

    function automatic logic [127:0] rk_known(input int k);
        case (k)
            0:       return K1;
            1:       return RK1;
            2:       return RK2;
            3:       return RK3;
            default: return '0;
        endcase
    endfunction

    // Drive the read index for this cycle, queue the expectation, advance one edge.
    task automatic step(input string nm, input logic [3:0] idx,
                        input logic hit, input logic err, input logic chkd, input logic [127:0] dat,
                        input logic rdy, input logic bsy, input logic kv, input logic dn);
        exp_t e;
        rk_rd_idx = idx;
        e.name = nm; e.hit = hit; e.err = err; e.chkd = chkd; e.data = dat;
        e.rdy = rdy; e.bsy = bsy; e.kv = kv; e.dn = dn;
        sb_q.push_back(e);
        @(posedge eph1);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rk_rd_idx = '0;
        repeat (2) @(posedge eph1);
        #1;
        reset = 1'b0;

        if (key_ready !== 1'b1) begin
            $display("FAIL reset_key_ready: got %b want 1", key_ready);
            fail_cnt++;
        end
        if (busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b want 0", busy);
            fail_cnt++;
        end
        if (done !== 1'b0) begin
            $display("FAIL reset_done: got %b want 0", done);
            fail_cnt++;
        end
        if (keys_valid !== 1'b0) begin
            $display("FAIL reset_keys_valid: got %b want 0", keys_valid);
            fail_cnt++;
        end

        // Reset state and out-of-range reads in IDLE.
        step("rst_idle",  4'd0,  0, 0, 0, '0, 1, 0, 0, 0);
        step("idle_err11", 4'd11, 0, 1, 1, '0, 1, 0, 0, 0);

        // Load K1; read index 3 throughout expansion.
        key_valid = 1'b1; key_in = K1;
        step("t1_accept", 4'd15, 0, 1, 1, '0, 1, 0, 0, 0);
        key_valid = 1'b0;
        for (int k = 0; k < 10; k++)
            step($sformatf("t1_rd3_after_e%0d", k), 4'd3, (k >= 3), 0, (k >= 3), RK3, 0, 1, 0, 0);
        step("t1_done_rk10", 4'd10, 1, 0, 1, RK10, 1, 0, 1, 1);
        step("t1_rk1",       4'd1,  1, 0, 1, RK1,  1, 0, 1, 0);
        step("t1_rk2",       4'd2,  1, 0, 1, RK2,  1, 0, 1, 0);
        step("t1_rk0",       4'd0,  1, 0, 1, K1,   1, 0, 1, 0);
        step("ready_err15",  4'd15, 0, 1, 1, '0,   1, 0, 1, 0);

        // K1 again, then K2 held on the bus through the whole expansion.
        key_valid = 1'b1; key_in = K1;
        step("t3_accept_k1", 4'd10, 1, 0, 1, RK10, 1, 0, 1, 0);
        key_in = K2;
        for (int k = 0; k < 10; k++)
            step($sformatf("t3_hold_after_e%0d", k), 4'd0, 1, 0, 1, K1, 0, 1, 0, 0);
        step("t3_first_ready_old_rd", 4'd0, 1, 0, 1, K1, 1, 0, 1, 1);
        key_valid = 1'b0;
        step("t3_k2_rk0",     4'd0,  1, 0, 1, K2, 0, 1, 0, 0);
        step("t3_k2_rk2_miss", 4'd2, 0, 0, 0, '0, 0, 1, 0, 0);
        step("t3_k2_rk2_hit", 4'd2,  1, 0, 0, '0, 0, 1, 0, 0);
        step("expand_err15",  4'd15, 0, 1, 1, '0, 0, 1, 0, 0);

        // Reset sampled at E5 of the K2 expansion.
        reset = 1'b1;
        step("t4_pre_reset", 4'd0, 1, 0, 1, K2, 0, 1, 0, 0);
        reset = 1'b0;
        for (int i = 0; i <= 10; i++)
            step($sformatf("t4_idle_miss_%0d", i), 4'(i), 0, 0, 0, '0, 1, 0, 0, 0);

        // Reload K1 after the aborted expansion.
        key_valid = 1'b1; key_in = K1;
        step("t4_accept", 4'd11, 0, 1, 1, '0, 1, 0, 0, 0);
        key_valid = 1'b0;
        for (int k = 0; k < 10; k++)
            step($sformatf("t4_rd%0d_after_e%0d", k, k), 4'(k), 1, 0, (k <= 3), rk_known(k), 0, 1, 0, 0);
        step("t4_done_rk10", 4'd10, 1, 0, 1, RK10, 1, 0, 1, 1);
        step("t4_rk3",       4'd3,  1, 0, 1, RK3,  1, 0, 1, 0);

`ifdef AES_KS_ZEROIZE_EN
        // Zeroize in READY, then reload K2.
        zeroize = 1'b1;
        step("t6_zeroize_cycle", 4'd0, 1, 0, 1, K1, 1, 0, 1, 0);
        zeroize = 1'b0;
        key_valid = 1'b1; key_in = K2;
        step("t6_after_zeroize", 4'd0, 0, 0, 0, '0, 1, 0, 0, 0);
        key_valid = 1'b0;
        step("t6_reload_rk0",    4'd0, 1, 0, 1, K2, 0, 1, 0, 0);
`endif

        @(negedge eph1);
        #1;
        if (chk_cnt == 0) begin
            $display("FAIL no scoreboard checks executed");
            fail_cnt++;
        end
        if (pass_cnt != chk_cnt) begin
            $display("FAIL scoreboard: %0d of %0d checks failed", chk_cnt - pass_cnt, chk_cnt);
            fail_cnt++;
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        if (fail_cnt == 0) $display("PASS");
        else               $display("FAIL %0d error(s)", fail_cnt);
        $finish;
    end

endmodule
